mem_sram_ctrl: RTL and testbench
================================

// Module: mem_sram_ctrl
// PURPOSE
//  MEM-stage controller behind the EXE ALU. Takes the ALU result as a byte address,
//  performs one 32-bit LDR/STR as two 16-bit accesses on an external SRAM, and drops
//  ready for the whole transaction so the hazard/freeze logic stalls the pipeline.
// PARAMETERS
//  ADDR_BASE    1024  byte address that maps to SRAM word 0
//  SRAM_AW      18    SRAM address width (16-bit locations)
//  WAIT_CYCLES  1     extra cycles each half-access is held on the bus (0..7)
// PORTS
//  clk          in   1        single clock, all state on rising edge
//  rst          in   1        synchronous, active-high reset
//  wr_en        in   1        STR request; held until ready=1
//  rd_en        in   1        LDR request; held until ready=1
//  address      in   32       byte address (ALU out); bits [1:0] ignored
//  wdata        in   32       store data (Rd value)
//  rdata        out  32       load data; valid in the cycle ready=1 ends a read
//  ready        out  1        1 = no transaction pending; 0 = freeze pipeline
//  sram_addr    out  SRAM_AW  SRAM location address
//  sram_we_n    out  1        SRAM write strobe, active low
//  sram_dq_out  out  16       data driven to SRAM
//  sram_dq_oe   out  1        1 = controller drives the DQ bus
//  sram_dq_in   in   16       data returned by SRAM
// BEHAVIOUR
//  Reset: state=IDLE, rdata=0, sram_addr=0, sram_we_n=1, sram_dq_out=0, sram_dq_oe=0,
//   counter=0. rst mid-transaction aborts it; bus released the next cycle; no rdata update.
//  Word index w = ((address - ADDR_BASE) mod 2^32) >> 2, truncated to SRAM_AW-1 bits.
//   Low half lives at {w,1'b0}, high half at {w,1'b1}. Out-of-range addresses wrap silently.
//  FSM states IDLE -> LO -> HI -> DONE -> IDLE.
//   IDLE: ready = ~(rd_en|wr_en) (combinational). On a request, latch address,
//    wdata and op into registers, then go to LO. If both enables are high, the
//    request is a write.
//   LO: stay WAIT_CYCLES+1 cycles. sram_addr={w,0}. Write: sram_we_n=0,
//    sram_dq_oe=1, sram_dq_out=wdata[15:0]. Read: sram_we_n=1, sram_dq_oe=0.
//    On the last LO cycle, sample sram_dq_in into an internal low buffer.
//   HI: same as LO with address {w,1}, data wdata[31:16]. On the last cycle of a
//    read, rdata <= {sram_dq_in, low_buf}.
//   DONE: ready=1 for exactly one cycle, bus idle (we_n=1, oe=0). Enables are
//    ignored in DONE. Next state is IDLE; a request held there starts a new
//    transaction.
//  Latency: request first seen at cycle t. DONE (ready=1) occurs at t+2*(WAIT_CYCLES+1)+1.
//   ready=0 in cycles t..t+2*(WAIT_CYCLES+1), i.e. 5 cycles at default.
//  rdata is unchanged by writes and holds its value between reads.
//  The latched address/wdata are used for the whole transaction; input changes
//   mid-transaction have no effect.
//  sram_we_n never toggles within a phase. Between LO and HI it stays 0 for writes (no
//   glitch); in DONE/IDLE it is always 1.
// TESTING
//  1 Reset: rst=1 for 2 cycles with wr_en=1 -> ready=1 after rst drops (once wr_en=0),
//    we_n=1, oe=0, rdata=0.
//  2 STR address=1024+8, wdata=32'hDEADBEEF, W=1 -> we_n=0 with addr=4, dq=BEEF for
//    2 cycles, then addr=5, dq=DEAD for 2 cycles. ready=1 exactly 5 cycles after request.
//  3 LDR address=1032 with SRAM model loaded -> rdata=32'hDEADBEEF in the ready cycle.
//    Also check ready=0 for 5 cycles and oe=0 throughout.
//  4 Back-to-back STR then LDR (enables held across DONE) -> two full transactions,
//    one DONE cycle between them. rdata unchanged after the STR.
//  5 rd_en=wr_en=1 -> write performed, rdata unchanged. Also address=1020 -> wraps to the
//    top SRAM word {all-ones,x} with no error.
//  6 rst asserted during HI of a read -> IDLE next cycle, bus released, rdata keeps its old value.
//    WAIT_CYCLES=0 rerun of test 3 -> ready after 3 cycles.

Source files
------------

// File: rtl/mem_sram_ctrl_if.sv
// Bundle between the MEM-stage pipeline/SRAM pins and mem_sram_ctrl.
// The controller takes the slave view; the pipeline side (and the SRAM) the master view.
interface mem_sram_ctrl_if #(
  parameter int SRAM_AW = 18
);
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        address;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_we_n;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;

  modport master (
    output wr_en, rd_en, address, wdata, sram_dq_in,
    input  rdata, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );

  modport slave (
    input  wr_en, rd_en, address, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// MEM-stage SRAM controller: one 32-bit load/store split into two 16-bit SRAM
// accesses (low half then high half), with ready low for the whole transaction.
module mem_sram_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  mem_sram_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int         WAW      = SRAM_AW - 1;
  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  state_t             state_r;
  logic [2:0]         cnt_r;
  logic [WAW-1:0]     word_r;
  logic [31:0]        wdata_r;
  logic               is_wr_r;
  logic [15:0]        low_buf_r;
  logic [31:0]        rdata_r;
  logic [SRAM_AW-1:0] sram_addr_r;
  logic               we_n_r;
  logic [15:0]        dq_out_r;
  logic               dq_oe_r;

  logic [WAW-1:0]     word_s;
  logic               req_s;
  logic               last_s;
  logic               ready_s;

  // Word index decode, request detect, phase-end detect and the ready flag.
  always_comb begin
    word_s = WAW'((bus.address - ADDR_BASE) >> 2'd2);
    req_s  = bus.rd_en | bus.wr_en;
    last_s = (cnt_r == LAST_CNT);
    case (state_r)
      IDLE:    ready_s = ~req_s;
      DONE:    ready_s = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  // Transaction FSM; bus outputs are loaded on the edge that enters each phase
  // so they are stable for the whole phase and we_n stays low across LO->HI.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      word_r      <= '0;
      wdata_r     <= 32'd0;
      is_wr_r     <= 1'b0;
      low_buf_r   <= 16'd0;
      rdata_r     <= 32'd0;
      sram_addr_r <= '0;
      we_n_r      <= 1'b1;
      dq_out_r    <= 16'd0;
      dq_oe_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            word_r      <= word_s;
            wdata_r     <= bus.wdata;
            is_wr_r     <= bus.wr_en;
            cnt_r       <= 3'd0;
            sram_addr_r <= {word_s, 1'b0};
            we_n_r      <= ~bus.wr_en;
            dq_oe_r     <= bus.wr_en;
            dq_out_r    <= bus.wdata[15:0];
            state_r     <= LO;
          end
        end
        LO: begin
          if (last_s) begin
            low_buf_r   <= bus.sram_dq_in;
            cnt_r       <= 3'd0;
            sram_addr_r <= {word_r, 1'b1};
            dq_out_r    <= wdata_r[31:16];
            state_r     <= HI;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        HI: begin
          if (last_s) begin
            if (!is_wr_r) begin
              rdata_r <= {bus.sram_dq_in, low_buf_r};
            end
            cnt_r   <= 3'd0;
            we_n_r  <= 1'b1;
            dq_oe_r <= 1'b0;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.rdata       = rdata_r;
  assign bus.ready       = ready_s;
  assign bus.sram_addr   = sram_addr_r;
  assign bus.sram_we_n   = we_n_r;
  assign bus.sram_dq_out = dq_out_r;
  assign bus.sram_dq_oe  = dq_oe_r;
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: directed scenarios plus randomized
// load/store traffic against a word-level reference memory.
module tb_mem_sram_ctrl;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  mem_sram_ctrl_if #(.SRAM_AW(AW)) b1 ();
  mem_sram_ctrl_if #(.SRAM_AW(AW)) b0 ();

  mem_sram_ctrl #(.ADDR_BASE(32'd1024), .SRAM_AW(AW), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );
  mem_sram_ctrl #(.ADDR_BASE(32'd1024), .SRAM_AW(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );

  // Asynchronous 16-bit SRAM models, evaluated on the falling edge.
  logic [15:0] mem1 [int];
  logic [15:0] mem0 [int];

  always @(negedge clk) begin
    if (b1.sram_we_n === 1'b0) mem1[int'(b1.sram_addr)] = b1.sram_dq_out;
    if (b0.sram_we_n === 1'b0) mem0[int'(b0.sram_addr)] = b0.sram_dq_out;
    b1.sram_dq_in = mem1.exists(int'(b1.sram_addr)) ? mem1[int'(b1.sram_addr)] : 16'h0000;
    b0.sram_dq_in = mem0.exists(int'(b0.sram_addr)) ? mem0[int'(b0.sram_addr)] : 16'h0000;
  end

  // Per-cycle observations of the most recent transaction.
  logic           tr_ready [64];
  logic [AW-1:0]  tr_addr  [64];
  logic           tr_we    [64];
  logic           tr_oe    [64];
  logic [15:0]    tr_dq    [64];

  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd1;

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off / 32'd4) % 32'd131072);
  endfunction

  function automatic logic [15:0] peek1(input int a);
    return mem1.exists(a) ? mem1[a] : 16'hxxxx;
  endfunction

  task automatic drive(input bit use_w0, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] wd);
    if (use_w0) begin
      b0.wr_en = wr; b0.rd_en = rd; b0.address = a; b0.wdata = wd;
    end else begin
      b1.wr_en = wr; b1.rd_en = rd; b1.address = a; b1.wdata = wd;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after ready=1 (enables still held).
  task automatic run_txn(input bit use_w0, input logic wr, input logic rd,
                         input logic [31:0] a, input logic [31:0] wd, input bit scramble,
                         output int lat, output logic [31:0] rd_out);
    lat    = -1;
    rd_out = 32'hxxxx_xxxx;
    drive(use_w0, wr, rd, a, wd);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (use_w0) begin
        tr_ready[i] = b0.ready; tr_addr[i] = b0.sram_addr; tr_we[i] = b0.sram_we_n;
        tr_oe[i] = b0.sram_dq_oe; tr_dq[i] = b0.sram_dq_out;
      end else begin
        tr_ready[i] = b1.ready; tr_addr[i] = b1.sram_addr; tr_we[i] = b1.sram_we_n;
        tr_oe[i] = b1.sram_dq_oe; tr_dq[i] = b1.sram_dq_out;
      end
      if (i > 0 && tr_ready[i] === 1'b1) begin
        lat    = i;
        rd_out = use_w0 ? b0.rdata : b1.rdata;
        break;
      end
      @(posedge clk); #1;
      if (scramble && i == 0) drive(use_w0, wr, rd, $urandom, $urandom);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'd1024, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 1'b0, 32'd1024, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    nvec++; if (b1.ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", b1.ready); end
    nvec++; if (b1.sram_we_n !== 1'b1) begin nerr++; $display("FAIL reset_we_n: got %b want 1", b1.sram_we_n); end
    nvec++; if (b1.sram_dq_oe !== 1'b0) begin nerr++; $display("FAIL reset_oe: got %b want 0", b1.sram_dq_oe); end
    nvec++; if (b1.rdata !== 32'd0) begin nerr++; $display("FAIL reset_rdata: got %h want 0", b1.rdata); end
    nvec++; if (b1.sram_addr !== 18'd0) begin nerr++; $display("FAIL reset_addr: got %h want 0", b1.sram_addr); end
    nvec++; if (b1.sram_dq_out !== 16'd0) begin nerr++; $display("FAIL reset_dq: got %h want 0", b1.sram_dq_out); end
    nvec++; if (b0.ready !== 1'b1) begin nerr++; $display("FAIL reset_ready_w0: got %b want 1", b0.ready); end
    nvec++; if (b0.rdata !== 32'd0) begin nerr++; $display("FAIL reset_rdata_w0: got %h want 0", b0.rdata); end
    @(posedge clk); #1;
  endtask

  // Read of word 20 aborted by rst in its last HI cycle; rdata is still 0 from reset.
  task automatic test_abort();
    mem1[40] = 16'h1234;
    mem1[41] = 16'h5678;
    drive(1'b0, 1'b0, 1'b1, 32'd1104, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++; if (b1.sram_addr !== 18'd41) begin nerr++; $display("FAIL abort_hi_addr: got %0d want 41", b1.sram_addr); end
    nvec++; if (b1.ready !== 1'b0) begin nerr++; $display("FAIL abort_hi_ready: got %b want 0", b1.ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    nvec++; if (b1.ready !== 1'b1) begin nerr++; $display("FAIL abort_ready: got %b want 1", b1.ready); end
    nvec++; if (b1.sram_we_n !== 1'b1) begin nerr++; $display("FAIL abort_we_n: got %b want 1", b1.sram_we_n); end
    nvec++; if (b1.sram_dq_oe !== 1'b0) begin nerr++; $display("FAIL abort_oe: got %b want 0", b1.sram_dq_oe); end
    nvec++; if (b1.rdata !== 32'd0) begin nerr++; $display("FAIL abort_rdata: got %h want 0", b1.rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_str();
    int lat;
    logic [31:0] rd;
    run_txn(1'b0, 1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF, 1'b0, lat, rd);
    idle();
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL str_latency: got %0d want 5", lat); end
    for (int i = 0; i < 5; i++) begin
      nvec++; if (tr_ready[i] !== 1'b0) begin nerr++; $display("FAIL str_ready c%0d: got %b want 0", i, tr_ready[i]); end
    end
    for (int i = 1; i < 5; i++) begin
      nvec++;
      if (tr_we[i] !== 1'b0 || tr_oe[i] !== 1'b1 ||
          tr_addr[i] !== ((i < 3) ? 18'd4 : 18'd5) || tr_dq[i] !== ((i < 3) ? 16'hBEEF : 16'hDEAD)) begin
        nerr++;
        $display("FAIL str_bus c%0d: got we_n=%b oe=%b addr=%0d dq=%h", i, tr_we[i], tr_oe[i], tr_addr[i], tr_dq[i]);
      end
    end
    nvec++; if (tr_we[5] !== 1'b1 || tr_oe[5] !== 1'b0) begin nerr++; $display("FAIL str_done_bus: got we_n=%b oe=%b want 1 0", tr_we[5], tr_oe[5]); end
    nvec++; if (rd !== 32'd0) begin nerr++; $display("FAIL str_rdata: got %h want 0", rd); end
    nvec++; if (peek1(4) !== 16'hBEEF || peek1(5) !== 16'hDEAD) begin nerr++; $display("FAIL str_mem: got %h %h want BEEF DEAD", peek1(4), peek1(5)); end
  endtask

  task automatic test_ldr();
    int lat;
    logic [31:0] rd;
    run_txn(1'b0, 1'b0, 1'b1, 32'd1032, 32'h0000_0000, 1'b0, lat, rd);
    idle();
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL ldr_latency: got %0d want 5", lat); end
    nvec++; if (rd !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL ldr_rdata: got %h want deadbeef", rd); end
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if (tr_oe[i] !== 1'b0 || tr_we[i] !== 1'b1 || tr_ready[i] !== (i == 5)) begin
        nerr++;
        $display("FAIL ldr_bus c%0d: got oe=%b we_n=%b ready=%b", i, tr_oe[i], tr_we[i], tr_ready[i]);
      end
    end
    nvec++; if (tr_addr[2] !== 18'd4 || tr_addr[3] !== 18'd5) begin nerr++; $display("FAIL ldr_addr: got %0d %0d want 4 5", tr_addr[2], tr_addr[3]); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rd;
    logic [31:0] wd;
    wd = $urandom;
    run_txn(1'b0, 1'b1, 1'b0, 32'd1144, wd, 1'b0, lat, rd);
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL b2b_str_latency: got %0d want 5", lat); end
    nvec++; if (rd !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL b2b_str_rdata: got %h want deadbeef", rd); end
    run_txn(1'b0, 1'b0, 1'b1, 32'd1144, 32'h0000_0000, 1'b0, lat, rd);
    idle();
    nvec++; if (tr_ready[0] !== 1'b0) begin nerr++; $display("FAIL b2b_gap_ready: got %b want 0", tr_ready[0]); end
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL b2b_ldr_latency: got %0d want 5", lat); end
    nvec++; if (rd !== wd) begin nerr++; $display("FAIL b2b_ldr_rdata: got %h want %h", rd, wd); end
    ref_mem[widx(32'd1144)] = wd;
    exp_rd1 = wd;
  endtask

  task automatic test_both_en();
    int lat;
    logic [31:0] rd;
    logic [31:0] wd;
    wd = $urandom;
    run_txn(1'b0, 1'b1, 1'b1, 32'd1020, wd, 1'b0, lat, rd);
    idle();
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL both_latency: got %0d want 5", lat); end
    nvec++; if (tr_we[1] !== 1'b0 || tr_oe[1] !== 1'b1) begin nerr++; $display("FAIL both_is_write: got we_n=%b oe=%b want 0 1", tr_we[1], tr_oe[1]); end
    nvec++; if (tr_addr[1] !== 18'h3FFFE || tr_addr[3] !== 18'h3FFFF) begin nerr++; $display("FAIL wrap_addr: got %h %h want 3fffe 3ffff", tr_addr[1], tr_addr[3]); end
    nvec++; if (rd !== exp_rd1) begin nerr++; $display("FAIL both_rdata: got %h want %h", rd, exp_rd1); end
    run_txn(1'b0, 1'b0, 1'b1, 32'd1020, 32'h0000_0000, 1'b0, lat, rd);
    idle();
    nvec++; if (rd !== wd) begin nerr++; $display("FAIL wrap_readback: got %h want %h", rd, wd); end
    ref_mem[widx(32'd1020)] = wd;
    exp_rd1 = wd;
  endtask

  task automatic test_wait0();
    int lat;
    logic [31:0] rd;
    run_txn(1'b1, 1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF, 1'b0, lat, rd);
    idle();
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL w0_str_latency: got %0d want 3", lat); end
    nvec++;
    if (tr_addr[1] !== 18'd4 || tr_dq[1] !== 16'hBEEF || tr_addr[2] !== 18'd5 || tr_dq[2] !== 16'hDEAD ||
        tr_we[1] !== 1'b0 || tr_we[2] !== 1'b0) begin
      nerr++;
      $display("FAIL w0_str_bus: got %0d:%h %0d:%h we_n=%b%b", tr_addr[1], tr_dq[1], tr_addr[2], tr_dq[2], tr_we[1], tr_we[2]);
    end
    run_txn(1'b1, 1'b0, 1'b1, 32'd1032, 32'h0000_0000, 1'b0, lat, rd);
    idle();
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL w0_ldr_latency: got %0d want 3", lat); end
    nvec++; if (rd !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL w0_ldr_rdata: got %h want deadbeef", rd); end
    nvec++; if (tr_ready[0] !== 1'b0 || tr_ready[1] !== 1'b0 || tr_ready[2] !== 1'b0) begin nerr++; $display("FAIL w0_ready_low: got %b%b%b want 000", tr_ready[0], tr_ready[1], tr_ready[2]); end
  endtask

  task automatic test_random();
    logic [31:0] pool [20];
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] ref_rd;
    int lat;
    int op;
    int w;
    for (int k = 0; k < 16; k++) pool[k] = 32'd1024 + 32'd4 * (32'd100 + 32'(k));
    for (int k = 16; k < 20; k++) begin
      do begin
        pool[k] = $urandom & 32'hFFFF_FFFC;
        w = widx(pool[k]);
      end while (w < 200 || w == 131071);
    end
    ref_rd = exp_rd1;
    for (int n = 0; n < 60; n++) begin
      a  = pool[$urandom_range(0, 19)] | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      wd = $urandom;
      run_txn(1'b0, op != 0, op != 1, a, wd, $urandom_range(0, 1) == 1, lat, rd);
      w = widx(a);
      if (op != 0) ref_mem[w] = wd;
      else ref_rd = ref_mem.exists(w) ? ref_mem[w] : 32'd0;
      nvec++; if (lat !== 5) begin nerr++; $display("FAIL rand_latency n%0d: got %0d want 5", n, lat); end
      nvec++; if (rd !== ref_rd) begin nerr++; $display("FAIL rand_rdata n%0d op%0d a=%h: got %h want %h", n, op, a, rd, ref_rd); end
      if ($urandom_range(0, 1) == 1) begin
        idle();
        @(posedge clk); #1;
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_abort();
    test_str();
    test_ldr();
    test_back_to_back();
    test_both_en();
    test_wait0();
    test_random();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
